// File: rtl/session_lup_tracker.sv
// session_lup_tracker: in-order tracker between the TOE session-lookup master
// and the cuckoo CAM lookup slave. Forwards requests through a registered skid
// stage, records forwarded keys in a tracking FIFO, caps outstanding lookups,
// forwards CAM replies, and synthesises a miss when the head request times out.
// CAM replies that arrive after their miss was synthesised are discarded.
//
// Ports:
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   s_req_*  (72b)        lookup requests from TOE ([63:0] key, [71:64] tag)
//   m_req_*  (72b)        lookup requests to CAM
//   s_rsp_*  (88b)        CAM replies ([71:0] request, [72] hit, [87:73] sid)
//   m_rsp_*  (88b)        replies to TOE
//   outstanding           tracking FIFO occupancy after the previous edge
//   stat_*                statistics, only with SESSION_LUP_TRACKER_STATS_EN
//
// Optional feature macro: SESSION_LUP_TRACKER_STATS_EN
module session_lup_tracker #(
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned DROP_W  = 6
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [71:0]                s_req_tdata,
  input  logic                       s_req_tvalid,
  output logic                       s_req_tready,
  output logic [71:0]                m_req_tdata,
  output logic                       m_req_tvalid,
  input  logic                       m_req_tready,
  input  logic [87:0]                s_rsp_tdata,
  input  logic                       s_rsp_tvalid,
  output logic                       s_rsp_tready,
  output logic [87:0]                m_rsp_tdata,
  output logic                       m_rsp_tvalid,
  input  logic                       m_rsp_tready,
  output logic [$clog2(MAX_OUT):0]   outstanding
`ifdef SESSION_LUP_TRACKER_STATS_EN
  ,
  output logic [31:0]                stat_timeouts,
  output logic [31:0]                stat_late_drops,
  output logic [$clog2(MAX_OUT):0]   stat_peak_out,
  output logic                       stat_err_orphan
`endif
);

  localparam int unsigned AW = $clog2(MAX_OUT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FWD, SYNTH} state_t;

  // Request skid stage
  logic        skid_valid, skid_v_nxt, mreq_v_nxt, sreq_rdy_nxt;
  logic [71:0] skid_data, skid_d_nxt, mreq_d_nxt;
  logic        req_acc, req_push;

  // Tracking FIFO
  logic [71:0] mem [MAX_OUT];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ_nxt;
  logic [71:0] head;
  logic        fifo_empty, pop_c;

  // Timeout and reply FSM
  logic [TW-1:0]     tmo_cnt;
  state_t            state, state_nxt;
  logic              mrsp_v_nxt, srsp_rdy_nxt, orphan_nxt, err_orphan, rsp_hs;
  logic [87:0]       mrsp_d_nxt;
  logic [DROP_W-1:0] drop_cnt, drop_nxt;

  assign req_acc    = s_req_tvalid && s_req_tready;
  assign req_push   = m_req_tvalid && m_req_tready;
  assign rsp_hs     = s_rsp_tvalid && s_rsp_tready;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Skid next state; the skid register only fills while m_req is stalled
  always_comb begin
    mreq_v_nxt = m_req_tvalid;
    mreq_d_nxt = m_req_tdata;
    skid_v_nxt = skid_valid;
    skid_d_nxt = skid_data;
    if (!m_req_tvalid || m_req_tready) begin
      if (skid_valid) begin
        mreq_v_nxt = 1'b1;
        mreq_d_nxt = skid_data;
        skid_v_nxt = 1'b0;
      end else begin
        mreq_v_nxt = req_acc;
        if (req_acc) mreq_d_nxt = s_req_tdata;
      end
    end else if (req_acc) begin
      skid_v_nxt = 1'b1;
      skid_d_nxt = s_req_tdata;
    end
  end

  // Ready is registered from post-edge occupancy so one more accept never overflows
  always_comb begin
    wr_nxt       = wr_ptr + CW'(req_push);
    rd_nxt       = rd_ptr + CW'(pop_c);
    occ_nxt      = wr_nxt - rd_nxt;
    sreq_rdy_nxt = !skid_v_nxt && ((SW'(occ_nxt) + SW'(mreq_v_nxt)) < SW'(MAX_OUT));
  end

  // Request stage and FIFO pointers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_req_tvalid <= 1'b0;
      m_req_tdata  <= '0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      s_req_tready <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
    end else begin
      m_req_tvalid <= mreq_v_nxt;
      m_req_tdata  <= mreq_d_nxt;
      skid_valid   <= skid_v_nxt;
      skid_data    <= skid_d_nxt;
      s_req_tready <= sreq_rdy_nxt;
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      outstanding  <= occ_nxt;
    end
  end

  // FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge ap_clk) begin
    if (req_push) mem[wr_ptr[AW-1:0]] <= m_req_tdata;
  end

  // Head-of-line age, saturating at TIMEOUT
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                         tmo_cnt <= '0;
    else if (pop_c || fifo_empty)       tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT))   tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Reply FSM state register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= IDLE;
      m_rsp_tvalid <= 1'b0;
      m_rsp_tdata  <= '0;
      s_rsp_tready <= 1'b0;
      drop_cnt     <= '0;
      err_orphan   <= 1'b0;
    end else begin
      state        <= state_nxt;
      m_rsp_tvalid <= mrsp_v_nxt;
      m_rsp_tdata  <= mrsp_d_nxt;
      s_rsp_tready <= srsp_rdy_nxt;
      drop_cnt     <= drop_nxt;
      err_orphan   <= orphan_nxt;
    end
  end

  // Reply FSM next state; an accepted CAM reply always beats a timeout
  always_comb begin
    state_nxt  = state;
    mrsp_v_nxt = m_rsp_tvalid;
    mrsp_d_nxt = m_rsp_tdata;
    drop_nxt   = drop_cnt;
    orphan_nxt = err_orphan;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        if (rsp_hs) begin
          if (drop_cnt != '0) begin
            drop_nxt = drop_cnt - DROP_W'(1);
          end else if (!fifo_empty) begin
            mrsp_d_nxt = s_rsp_tdata;
            mrsp_v_nxt = 1'b1;
            pop_c      = 1'b1;
            state_nxt  = FWD;
          end else begin
            orphan_nxt = 1'b1;
          end
        end else if (tmo_cnt == TW'(TIMEOUT)) begin
          mrsp_d_nxt = {15'h0, 1'b0, head};
          mrsp_v_nxt = 1'b1;
          pop_c      = 1'b1;
          if (drop_cnt != {DROP_W{1'b1}}) drop_nxt = drop_cnt + DROP_W'(1);
          state_nxt  = SYNTH;
        end
      end
      FWD, SYNTH: begin
        if (m_rsp_tready) begin
          mrsp_v_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    srsp_rdy_nxt = (state_nxt == IDLE);
  end

`ifdef SESSION_LUP_TRACKER_STATS_EN
  // Saturating statistics
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_timeouts   <= '0;
      stat_late_drops <= '0;
      stat_peak_out   <= '0;
    end else begin
      if (state == IDLE && state_nxt == SYNTH && stat_timeouts != 32'hFFFF_FFFF)
        stat_timeouts <= stat_timeouts + 32'd1;
      if (state == IDLE && rsp_hs && drop_cnt != '0 && stat_late_drops != 32'hFFFF_FFFF)
        stat_late_drops <= stat_late_drops + 32'd1;
      if (occ_nxt > stat_peak_out) stat_peak_out <= occ_nxt;
    end
  end

  assign stat_err_orphan = err_orphan;
`endif

endmodule

// File: tb/tb_session_lup_tracker.sv
// Testbench for session_lup_tracker: table-driven single transaction plus
// hand-written sequences for fill/backpressure, timeout, late drop, race and reset.
module tb_session_lup_tracker;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DROP_W  = 6;
  localparam int unsigned OW      = $clog2(MAX_OUT) + 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [71:0]   s_req_tdata = '0;
  logic          s_req_tvalid = 1'b0;
  logic          s_req_tready;
  logic [71:0]   m_req_tdata;
  logic          m_req_tvalid;
  logic          m_req_tready = 1'b1;
  logic [87:0]   s_rsp_tdata = '0;
  logic          s_rsp_tvalid = 1'b0;
  logic          s_rsp_tready;
  logic [87:0]   m_rsp_tdata;
  logic          m_rsp_tvalid;
  logic          m_rsp_tready = 1'b1;
  logic [OW-1:0] outstanding;
`ifdef SESSION_LUP_TRACKER_STATS_EN
  logic [31:0]   stat_timeouts, stat_late_drops;
  logic [OW-1:0] stat_peak_out;
  logic          stat_err_orphan;
`endif

  session_lup_tracker #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT), .DROP_W(DROP_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_req_tdata(s_req_tdata), .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .m_req_tdata(m_req_tdata), .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
    .s_rsp_tdata(s_rsp_tdata), .s_rsp_tvalid(s_rsp_tvalid), .s_rsp_tready(s_rsp_tready),
    .m_rsp_tdata(m_rsp_tdata), .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready),
    .outstanding(outstanding)
`ifdef SESSION_LUP_TRACKER_STATS_EN
    , .stat_timeouts(stat_timeouts), .stat_late_drops(stat_late_drops),
    .stat_peak_out(stat_peak_out), .stat_err_orphan(stat_err_orphan)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  logic [87:0] exp_q[$];

  typedef struct {
    logic          req_v;
    logic [71:0]   req_d;
    logic          rsp_v;
    logic [87:0]   rsp_d;
    logic          e_sreq_rdy;
    logic          e_mreq_v;
    logic [71:0]   e_mreq_d;
    logic          e_srsp_rdy;
    logic          e_mrsp_v;
    logic [87:0]   e_mrsp_d;
    logic [OW-1:0] e_out;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic vec_t row(input logic rv, input logic [71:0] rd, input logic sv,
                               input logic [87:0] sd, input logic esr, input logic emv,
                               input logic [71:0] emd, input logic ess, input logic erv,
                               input logic [87:0] erd, input logic [OW-1:0] eo);
    vec_t v;
    v.req_v = rv; v.req_d = rd; v.rsp_v = sv; v.rsp_d = sd;
    v.e_sreq_rdy = esr; v.e_mreq_v = emv; v.e_mreq_d = emd; v.e_srsp_rdy = ess;
    v.e_mrsp_v = erv; v.e_mrsp_d = erd; v.e_out = eo;
    return v;
  endfunction

  function automatic logic [87:0] cam(input logic [14:0] sid, input logic [71:0] k);
    return {sid, 1'b1, k};
  endfunction

  function automatic logic [87:0] synth(input logic [71:0] k);
    return {15'h0, 1'b0, k};
  endfunction

  // Every m_rsp handshake must match the next expected reply, in order
  always @(negedge ap_clk) begin
    if (!ap_rst && m_rsp_tvalid && m_rsp_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got %h expected no beat", m_rsp_tdata);
      end else begin
        check("rsp_beat", m_rsp_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic send_req(input logic [71:0] k);
    bit done = 0;
    s_req_tvalid = 1'b1;
    s_req_tdata  = k;
    for (int i = 0; i < 64 && !done; i++) begin
      if (s_req_tready) done = 1;
      tick();
    end
    s_req_tvalid = 1'b0;
    if (!done) check("send_req_timeout", 88'(s_req_tready), 88'(1));
  endtask

  task automatic send_rsp(input logic [87:0] d);
    bit done = 0;
    s_rsp_tvalid = 1'b1;
    s_rsp_tdata  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      if (s_rsp_tready) done = 1;
      tick();
    end
    s_rsp_tvalid = 1'b0;
    if (!done) check("send_rsp_timeout", 88'(s_rsp_tready), 88'(1));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      check(name, 88'(exp_q.size()), 88'(0));
      exp_q.delete();
    end
  endtask

  task automatic roundtrip(input logic [71:0] k, input logic [14:0] sid, input string name);
    send_req(k);
    tick();
    tick();
    exp_q.push_back(cam(sid, k));
    send_rsp(cam(sid, k));
    wait_drain(name);
  endtask

  logic [71:0] k1, k3, k4, k5;
  logic [87:0] r1;
  logic [71:0] fk[9];
  int n;

  initial begin
    k1 = {8'h05, 64'h1122_3344_5566_7788};
    r1 = {15'h0042, 1'b1, k1};

    // Reset state
    tick();
    tick();
    check("rst_sreq_rdy", 88'(s_req_tready), 88'(0));
    check("rst_srsp_rdy", 88'(s_rsp_tready), 88'(0));
    check("rst_mreq_v", 88'(m_req_tvalid), 88'(0));
    check("rst_mrsp_v", 88'(m_rsp_tvalid), 88'(0));
    check("rst_mrsp_d", m_rsp_tdata, 88'(0));
    check("rst_out", 88'(outstanding), 88'(0));
    ap_rst = 1'b0;

    // Single lookup, reply 10 cycles after the request
    tbl[0]  = row(0, '0, 0, '0, 1, 0, '0, 1, 0, '0, 0);
    tbl[1]  = row(1, k1, 0, '0, 1, 1, k1, 1, 0, '0, 0);
    for (int i = 2; i <= 10; i++) tbl[i] = row(0, '0, 0, '0, 1, 0, '0, 1, 0, '0, 1);
    tbl[11] = row(0, '0, 1, r1, 1, 0, '0, 0, 1, r1, 0);
    tbl[12] = row(0, '0, 0, '0, 1, 0, '0, 1, 0, '0, 0);
    exp_q.push_back(r1);
    for (int i = 0; i < 13; i++) begin
      s_req_tvalid = tbl[i].req_v;
      s_req_tdata  = tbl[i].req_d;
      s_rsp_tvalid = tbl[i].rsp_v;
      s_rsp_tdata  = tbl[i].rsp_d;
      tick();
      check($sformatf("v%0d_sreq_rdy", i), 88'(s_req_tready), 88'(tbl[i].e_sreq_rdy));
      check($sformatf("v%0d_mreq_v", i), 88'(m_req_tvalid), 88'(tbl[i].e_mreq_v));
      if (tbl[i].e_mreq_v) check($sformatf("v%0d_mreq_d", i), 88'(m_req_tdata), 88'(tbl[i].e_mreq_d));
      check($sformatf("v%0d_srsp_rdy", i), 88'(s_rsp_tready), 88'(tbl[i].e_srsp_rdy));
      check($sformatf("v%0d_mrsp_v", i), 88'(m_rsp_tvalid), 88'(tbl[i].e_mrsp_v));
      if (tbl[i].e_mrsp_v) check($sformatf("v%0d_mrsp_d", i), m_rsp_tdata, tbl[i].e_mrsp_d);
      check($sformatf("v%0d_out", i), 88'(outstanding), 88'(tbl[i].e_out));
    end
    s_req_tvalid = 1'b0;
    s_rsp_tvalid = 1'b0;
    wait_drain("v_drain");

    // Fill to MAX_OUT with CAM silent; ninth request waits for one reply
    for (int i = 0; i < 9; i++) fk[i] = {8'h20 + 8'(i), 32'hCAFE_0000, 32'(i)};
    n = 0;
    s_req_tvalid = 1'b1;
    s_req_tdata  = fk[0];
    for (int c = 0; c < 12; c++) begin
      if (s_req_tready) begin
        tick();
        n++;
        s_req_tdata = fk[(n < 9) ? n : 8];
      end else begin
        tick();
      end
    end
    check("fill_count", 88'(n), 88'(8));
    check("fill_rdy_low", 88'(s_req_tready), 88'(0));
    check("fill_out", 88'(outstanding), 88'(8));
    exp_q.push_back(cam(15'h100, fk[0]));
    s_rsp_tvalid = 1'b1;
    s_rsp_tdata  = cam(15'h100, fk[0]);
    check("release_srsp_rdy", 88'(s_rsp_tready), 88'(1));
    tick();
    s_rsp_tvalid = 1'b0;
    check("ninth_rdy", 88'(s_req_tready), 88'(1));
    tick();
    s_req_tvalid = 1'b0;
    check("ninth_mreq_v", 88'(m_req_tvalid), 88'(1));
    check("ninth_mreq_d", 88'(m_req_tdata), 88'(fk[8]));
    check("ninth_rdy_low", 88'(s_req_tready), 88'(0));
    for (int i = 1; i < 9; i++) begin
      exp_q.push_back(cam(15'h100 + 15'(i), fk[i]));
      send_rsp(cam(15'h100 + 15'(i), fk[i]));
    end
    wait_drain("fill_drain");
    tick();
    check("fill_out_end", 88'(outstanding), 88'(0));

    // Timeout: synthetic miss, then the late CAM reply is swallowed
    k3 = {8'h33, 64'hDEAD_BEEF_0000_0003};
    m_rsp_tready = 1'b0;
    send_req(k3);
    tick();
    check("to_out1", 88'(outstanding), 88'(1));
    for (int c = 0; c < 16; c++) begin
      tick();
      check("to_early", 88'(m_rsp_tvalid), 88'(0));
    end
    tick();
    check("to_mrsp_v", 88'(m_rsp_tvalid), 88'(1));
    check("to_mrsp_d", m_rsp_tdata, synth(k3));
    check("to_srsp_rdy", 88'(s_rsp_tready), 88'(0));
    check("to_out0", 88'(outstanding), 88'(0));
    exp_q.push_back(synth(k3));
    m_rsp_tready = 1'b1;
    tick();
    check("to_done_v", 88'(m_rsp_tvalid), 88'(0));
    check("late_srsp_rdy", 88'(s_rsp_tready), 88'(1));
    send_rsp(cam(15'h33, k3));
    for (int c = 0; c < 4; c++) begin
      check("late_no_rsp", 88'(m_rsp_tvalid), 88'(0));
      tick();
    end
    roundtrip({8'h34, 64'h0000_0000_0000_0034}, 15'h34, "late_after_rt");

    // CAM reply in the same cycle the head reaches TIMEOUT
    k4 = {8'h44, 64'h4444_0000_0000_0044};
    send_req(k4);
    tick();
    for (int c = 0; c < 16; c++) tick();
    exp_q.push_back(cam(15'h44, k4));
    s_rsp_tvalid = 1'b1;
    s_rsp_tdata  = cam(15'h44, k4);
    check("race_srsp_rdy", 88'(s_rsp_tready), 88'(1));
    tick();
    s_rsp_tvalid = 1'b0;
    check("race_mrsp_v", 88'(m_rsp_tvalid), 88'(1));
    check("race_mrsp_d", m_rsp_tdata, cam(15'h44, k4));
    for (int c = 0; c < 20; c++) tick();
    roundtrip({8'h45, 64'h0000_0000_0000_0045}, 15'h45, "race_after_rt");

    // Backpressure on m_rsp for 20 cycles
    k5 = {8'h55, 64'h5555_AAAA_5555_AAAA};
    m_rsp_tready = 1'b0;
    send_req(k5);
    tick();
    tick();
    send_rsp(cam(15'h55, k5));
    for (int c = 0; c < 20; c++) begin
      check("bp_mrsp_v", 88'(m_rsp_tvalid), 88'(1));
      check("bp_mrsp_d", m_rsp_tdata, cam(15'h55, k5));
      check("bp_srsp_rdy", 88'(s_rsp_tready), 88'(0));
      tick();
    end
    exp_q.push_back(cam(15'h55, k5));
    m_rsp_tready = 1'b1;
    tick();
    check("bp_done_v", 88'(m_rsp_tvalid), 88'(0));
    for (int c = 0; c < 4; c++) tick();
    check("bp_once", 88'(exp_q.size()), 88'(0));

    // Reset with drop_cnt=2 and three outstanding
    exp_q.push_back(synth({8'h61, 64'h61}));
    exp_q.push_back(synth({8'h62, 64'h62}));
    send_req({8'h61, 64'h61});
    send_req({8'h62, 64'h62});
    wait_drain("rst_prep_synth");
    send_req({8'h63, 64'h63});
    send_req({8'h64, 64'h64});
    send_req({8'h65, 64'h65});
    tick();
    check("rst_prep_out", 88'(outstanding), 88'(3));
    #3;
    ap_rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_sreq_rdy", 88'(s_req_tready), 88'(0));
    check("arst_srsp_rdy", 88'(s_rsp_tready), 88'(0));
    check("arst_mreq_v", 88'(m_req_tvalid), 88'(0));
    check("arst_mrsp_v", 88'(m_rsp_tvalid), 88'(0));
    check("arst_out", 88'(outstanding), 88'(0));
    tick();
    tick();
    ap_rst = 1'b0;
    tick();
    check("post_rst_sreq_rdy", 88'(s_req_tready), 88'(1));
    check("post_rst_srsp_rdy", 88'(s_rsp_tready), 88'(1));
    check("post_rst_out", 88'(outstanding), 88'(0));
`ifdef SESSION_LUP_TRACKER_STATS_EN
    check("post_rst_stat_to", 88'(stat_timeouts), 88'(0));
    check("post_rst_stat_ld", 88'(stat_late_drops), 88'(0));
    check("post_rst_stat_pk", 88'(stat_peak_out), 88'(0));
    check("post_rst_stat_or", 88'(stat_err_orphan), 88'(0));
`endif
    roundtrip({8'h66, 64'h6666_6666_6666_6666}, 15'h66, "post_rst_rt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
